// File: rtl/gray_convert_pipe.sv
`default_nettype none
// ============================================================================
// Module   : gray_convert_pipe
// Function : Pipelined Gray<->binary converter with valid/ready handshake on
//            both sides and a per-word direction select. Optional Gray
//            sequence checker enabled by defining GRAY_SEQ_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gray_convert_pipe #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    if (WIDTH < 2) begin : g_width_check
        $error("gray_convert_pipe: WIDTH must be at least 2");
    end
    if (CNT_W < 1) begin : g_cnt_check
        $error("gray_convert_pipe: CNT_W must be at least 1");
    end

    logic [WIDTH-1:0] w_g2b;
    logic [WIDTH-1:0] w_b2g;
    logic [WIDTH-1:0] w_conv;
    logic             w_accept;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Each binary bit is the parity of all Gray bits at or above it.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
        assign w_g2b[gi] = ^in_data[WIDTH-1:gi];
    end

    assign w_b2g    = in_data ^ (in_data >> 1);
    assign w_conv   = in_mode ? w_b2g : w_g2b;
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_data  <= w_conv;
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;

`ifdef GRAY_SEQ_CHECK_EN
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [WIDTH-1:0] r_hist;
    logic             r_hist_vld;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;
    logic [WIDTH-1:0] w_diff;
    logic             w_single;
    logic             w_gray_in;
    logic             w_viol;

    // Exactly one differing bit: non-zero and a power of two.
    assign w_diff    = in_data ^ r_hist;
    assign w_single  = (w_diff != '0) && ((w_diff & (w_diff - WIDTH'(1))) == '0);
    assign w_gray_in = w_accept && !in_mode;
    assign w_viol    = w_gray_in && r_hist_vld && !w_single;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist     <= '0;
            r_hist_vld <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (w_gray_in) begin
                r_hist     <= in_data;
                r_hist_vld <= 1'b1;
            end
            if (w_accept) begin
                r_err <= w_viol;
            end
            if (w_viol && (r_err_cnt != c_cnt_max)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign out_err   = r_err;
    assign err_count = r_err_cnt;
`else
    assign out_err   = 1'b0;
    assign err_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_convert_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_convert_pipe
// Function : Scoreboard bench for gray_convert_pipe (WIDTH=8 main instance,
//            WIDTH=3/CNT_W=1 instance for counter saturation).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_convert_pipe;

`ifdef GRAY_SEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic [7:0] cnt;
        int         cyc;
        bit         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_mode = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_err;
    logic [7:0] err_count;

    logic [2:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [2:0] s_out;
    logic       s_ovalid;
    logic       s_err;
    logic [0:0] s_cnt;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    gray_convert_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_mode(in_mode),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err),
        .err_count(err_count)
    );

    gray_convert_pipe #(.WIDTH(3), .CNT_W(1)) u_sat (
        .clk(clk), .rst(rst), .in_data(s_data), .in_mode(1'b0),
        .in_valid(s_valid), .in_ready(s_ready), .out_data(s_out),
        .out_valid(s_ovalid), .out_ready(1'b1), .out_err(s_err),
        .err_count(s_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Holds in_valid until the word is accepted; expected result queued at accept.
    task automatic send(input logic [7:0] d, input logic m, input logic [7:0] ed,
                        input logic ee, input logic [7:0] ec);
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{ed, ee, ec, cyc + 1, bit'(out_ready)});
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && sb.size() != 0; t++) begin
            @(posedge clk); #2;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
    endtask

    // Monitor: a transfer happens at the next rising edge when valid && ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_err", 32'(out_err), 32'(e.err));
                    check("err_count", 32'(err_count), 32'(e.cnt));
                    if (e.lat) check("latency", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] g3 [8];
        logic [7:0] gb;
        g3 = '{8'h0, 8'h1, 8'h3, 8'h2, 8'h6, 8'h7, 8'h5, 8'h4};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Exhaustive 3-bit Gray->binary, back-to-back
        for (int i = 0; i < 8; i++) send(g3[i], 1'b0, 8'(i), 1'b0, 8'd0);
        idle();
        drain();

        // Directed vectors; 0xF7 -> 0x80 differs in 6 bits
        do_reset();
        send(8'hA5, 1'b1, 8'hF7, 1'b0, 8'd0);
        send(8'hF7, 1'b0, 8'hA5, 1'b0, 8'd0);
        send(8'hFF, 1'b1, 8'h80, 1'b0, 8'd0);
        send(8'h80, 1'b0, 8'hFF, CHK, CHK ? 8'd1 : 8'd0);
        idle();
        drain();

        // Round trip over all 8-bit values, mixing modes word by word
        do_reset();
        for (int b = 0; b < 256; b++) begin
            gb = 8'(b) ^ (8'(b) >> 1);
            send(8'(b), 1'b1, gb, 1'b0, 8'd0);
            send(gb, 1'b0, 8'(b), 1'b0, 8'd0);
        end
        idle();
        drain();

        // Backpressure: first word held for 4 cycles while the next waits
        do_reset();
        out_ready = 1'b0;
        send(8'h01, 1'b0, 8'h01, 1'b0, 8'd0);
        in_data  = 8'h03;
        in_mode  = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_data", 32'(out_data), 32'h01);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(8'h03, 1'b0, 8'h02, 1'b0, 8'd0);
        send(8'h02, 1'b0, 8'h03, 1'b0, 8'd0);
        idle();
        drain();

        // Sequence checker: 000, 001, 111, 111
        do_reset();
        send(8'h00, 1'b0, 8'h00, 1'b0, 8'd0);
        send(8'h01, 1'b0, 8'h01, 1'b0, 8'd0);
        send(8'h07, 1'b0, 8'h05, CHK, CHK ? 8'd1 : 8'd0);
        send(8'h07, 1'b0, 8'h05, CHK, CHK ? 8'd2 : 8'd0);
        idle();
        drain();

        // Reset while a flagged word is held
        out_ready = 1'b0;
        send(8'h07, 1'b0, 8'h05, CHK, CHK ? 8'd3 : 8'd0);
        idle();
        @(negedge clk);
        check("mid_held_valid", 32'(out_valid), 32'd1);
        check("mid_held_cnt", 32'(err_count), CHK ? 32'd3 : 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_cnt", 32'(err_count), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Saturation with a 1-bit counter: 000,001,111,111,000 gives 3 violations
        s_valid = 1'b1;
        s_data = 3'b000; @(posedge clk); #1;
        s_data = 3'b001; @(posedge clk); #1;
        s_data = 3'b111; @(posedge clk); #1;
        @(negedge clk);
        check("sat_first", 32'(s_cnt), CHK ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        s_data = 3'b111; @(posedge clk); #1;
        s_data = 3'b000; @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("sat_cnt", 32'(s_cnt), CHK ? 32'd1 : 32'd0);
        check("sat_err", 32'(s_err), CHK ? 32'd1 : 32'd0);
        check("sat_data", 32'(s_out), 32'd0);
        check("sat_ready", 32'(s_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_convert_pipe.md
# gray_convert_pipe

Parametrised, pipelined Gray/binary code converter with a valid/ready stream interface on both sides and a per-transaction direction select. It supersedes the fixed 3-bit combinational Gray-to-binary table. It sits between encoder/counter sources and downstream arithmetic or display logic on the FPGA. An optional sequence checker flags accepted Gray words that are not a single-bit step from the previous one.

## Interface
Parameters:
- WIDTH, 3 — data width in bits, ≥ 2.
- CNT_W, 8 — width of the error counter, ≥ 1.

Ports:
- clk  input  1  — single clock, rising edge.
- rst  input  1  — synchronous, active-high reset.
- in_data  input  WIDTH  — word to convert.
- in_mode  input  1  — 0 = Gray→binary, 1 = binary→Gray; sampled with in_data.
- in_valid  input  1  — in_data/in_mode valid.
- in_ready  output  1  — block can accept this cycle.
- out_data  output  WIDTH  — converted word.
- out_valid  output  1  — out_data valid.
- out_ready  input  1  — downstream accepts this cycle.
- out_err  output  1  — sequence violation tied to the current out_data.
- err_count  output  CNT_W  — saturating count of violations.

## Operation
- Gray→binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i = WIDTH-2 down to 0.
- Binary→Gray: g = b ^ (b >> 1), logical shift.
- Single output register stage holds out_data, out_err and out_valid.
- in_ready = !out_valid || out_ready (combinational; no bubble under continuous flow).
- Accept = in_valid && in_ready. On accept, the output register loads the converted word and sets out_valid = 1.
- out_valid && out_ready with no accept in the same cycle clears out_valid.
- While out_valid && !out_ready, out_data, out_err and out_valid hold stable.
- in_valid while !in_ready: no effect, and no checker state update.
- Reset: out_valid = 0, out_data = 0, out_err = 0, err_count = 0, checker history cleared. in_ready = 1 in the first cycle after reset.
- Reset mid-transfer discards any held output word; no partial state survives.

## Timing
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: 1 word per cycle while out_ready = 1.
- Simultaneous output drain and input accept in one cycle: the new word replaces the old one, and out_valid stays 1.
- in_mode may change on every accepted word; each word converts according to its own mode.
- err_count updates in the same cycle the offending word is loaded, so it is visible when out_valid rises.
- err_count saturates at 2^CNT_W − 1 and does not wrap.

## Configuration
- Macro: GRAY_SEQ_CHECK_EN.
- Defined:
  - The checker stores the last accepted word with in_mode = 0, plus a history-valid flag.
  - On each accepted in_mode = 0 word with the history-valid flag set, a Hamming distance to the stored word ≠ 1 (this includes a repeated word) raises out_err for that output word and increments err_count.
  - The first Gray word after reset is never flagged.
  - Words with in_mode = 1 neither are checked nor update the history.
- Undefined: out_err and err_count are constant 0, and no checker logic is synthesised. Conversion, handshake and timing are unchanged.

## Test plan
- Exhaustive Gray→binary, WIDTH=3, out_ready=1:
  - Inputs: 000, 001, 011, 010, 110, 111, 101, 100 (back-to-back).
  - Required: outputs 000, 001, 010, 011, 100, 101, 110, 111, each 1 cycle after its input.
- Round trip, WIDTH=8:
  - For every binary b with in_mode=1, feed the result back with in_mode=0.
  - Required: the result equals b; e.g. 8'hA5 → Gray 8'hF7 → 8'hA5.
- Backpressure:
  - Hold out_ready=0 for 4 cycles after the first word.
  - Required: in_ready=0, and out_data stays stable and is not overwritten.
  - On release, all words arrive in order with no loss or duplication.
- Reset mid-stream:
  - Assert rst while out_valid=1.
  - Required: next cycle out_valid=0, out_data=0, err_count=0, in_ready=1.
- Checker (macro defined), WIDTH=3, Gray inputs 000, 001, 111, 111:
  - Required: out_err = 0, 0, 1, 1 and err_count ends at 2.
  - With CNT_W=1 and 3 violations, err_count saturates at 1.
- Macro undefined, same stimulus as the checker scenario:
  - Required: out_err=0 and err_count=0 throughout, with identical out_data.
